// File: rtl/dma_controller_pkg.sv
// ---------------------------------------------------------------------------
// dma_controller_pkg
// Shared definitions for the block DMA controller.
//   DEF_WORD_SIZE / DEF_BLOCK_SIZE : default address/length width and block width
//   BLOCK_WORDS                    : words carried by one device block
//   BLOCK_SHIFT                    : log2(BLOCK_WORDS), used for the ceil divide
//   state_e                        : controller state encoding (exported for debug)
// ---------------------------------------------------------------------------
package dma_controller_pkg;

  localparam int DEF_WORD_SIZE  = 16;
  localparam int DEF_BLOCK_SIZE = 64;
  localparam int BLOCK_WORDS    = 4;
  localparam int BLOCK_SHIFT    = $clog2(BLOCK_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WRITE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/dma_controller_if.sv
// ---------------------------------------------------------------------------
// dma_controller_if
// Bundles every DMA-facing signal except clock and reset.
//   Command : cmd_valid, cmd_addr, cmd_length -> DMA ; cmd_ready <- DMA
//   Bus     : BR <- DMA ; BG -> DMA
//   Device  : offset <- DMA ; dev_data -> DMA
//   Memory  : mem_write_req, mem_addr, mem_wdata <- DMA ; mem_write_ack -> DMA
//   Status  : dma_end_interrupt, dbg_state <- DMA
// Modports: master = the DMA controller, slave = its environment.
//
// Handshakes:
//   cmd   - a command is taken on a rising edge where cmd_valid and cmd_ready
//           are both 1; cmd_valid while cmd_ready=0 is dropped, never queued.
//   bus   - BR asks for the bus; device data is consumed only on an edge
//           where BR=1 and BG=1.
//   mem   - mem_write_req with mem_addr/mem_wdata stays asserted and stable
//           until an edge samples mem_write_ack=1; that edge completes it.
// ---------------------------------------------------------------------------
interface dma_controller_if
  import dma_controller_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
);

  logic                  cmd_valid;
  logic [WORD_SIZE-1:0]  cmd_addr;
  logic [WORD_SIZE-1:0]  cmd_length;
  logic                  cmd_ready;
  logic                  BR;
  logic                  BG;
  logic [WORD_SIZE-1:0]  offset;
  logic [BLOCK_SIZE-1:0] dev_data;
  logic                  mem_write_req;
  logic [WORD_SIZE-1:0]  mem_addr;
  logic [BLOCK_SIZE-1:0] mem_wdata;
  logic                  mem_write_ack;
  logic                  dma_end_interrupt;
  state_e                dbg_state;

  modport master (
    input  cmd_valid, cmd_addr, cmd_length, BG, dev_data, mem_write_ack,
    output cmd_ready, BR, offset, mem_write_req, mem_addr, mem_wdata,
           dma_end_interrupt, dbg_state
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_length, BG, dev_data, mem_write_ack,
    input  cmd_ready, BR, offset, mem_write_req, mem_addr, mem_wdata,
           dma_end_interrupt, dbg_state
  );

endinterface

// File: rtl/dma_controller.sv
// ---------------------------------------------------------------------------
// dma_controller
// Moves cmd_length words (rounded up to whole 4-word blocks) from an external
// device into memory starting at cmd_addr, one block per bus grant.
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : dma_controller_if.master (command, BR/BG, device, memory,
//              completion interrupt, debug state)
// Build option:
//   DMA_CYCLE_STEAL_EN - release the bus (BR=0) for one cycle after every
//                        non-final block. Undefined: BR is held for the whole
//                        transfer (burst mode).
// ---------------------------------------------------------------------------
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
) (
  input  logic             clk,
  input  logic             reset_n,
  dma_controller_if.master bus
);

  state_e                r_state;
  logic [WORD_SIZE-1:0]  r_base;
  logic [WORD_SIZE-1:0]  r_blocks_left;
  logic [WORD_SIZE-1:0]  r_offset;
  logic [BLOCK_SIZE-1:0] r_buffer;
  logic [WORD_SIZE-1:0]  r_mem_addr;
  logic                  r_br;
  logic                  r_mem_write_req;
  logic                  r_end_irq;

  // ceil(cmd_length / BLOCK_WORDS); one extra bit so length near 2^WORD_SIZE
  // does not overflow while rounding up.
  logic [WORD_SIZE:0]    w_len_round;
  logic [WORD_SIZE-1:0]  w_cmd_blocks;

  assign w_len_round  = {1'b0, bus.cmd_length} + (WORD_SIZE+1)'(BLOCK_WORDS - 1);
  assign w_cmd_blocks = WORD_SIZE'(w_len_round >> BLOCK_SHIFT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_base          <= '0;
      r_blocks_left   <= '0;
      r_offset        <= '0;
      r_buffer        <= '0;
      r_mem_addr      <= '0;
      r_br            <= 1'b0;
      r_mem_write_req <= 1'b0;
      r_end_irq       <= 1'b0;
    end else begin
      r_end_irq <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_base        <= bus.cmd_addr;
            r_blocks_left <= w_cmd_blocks;
            r_offset      <= '0;
            if (w_cmd_blocks == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_REQ;
              r_br    <= 1'b1;
            end
          end
        end

        ST_REQ: begin
          // Without a grant nothing moves: offset held, buffer untouched.
          if (bus.BG) begin
            r_buffer        <= bus.dev_data;
            r_mem_addr      <= r_base + r_offset;
            r_mem_write_req <= 1'b1;
            r_state         <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          // The block is already buffered, so BG is irrelevant here.
          if (bus.mem_write_ack) begin
            r_mem_write_req <= 1'b0;
            r_offset        <= r_offset + WORD_SIZE'(BLOCK_WORDS);
            r_blocks_left   <= r_blocks_left - WORD_SIZE'(1);
            if (r_blocks_left == WORD_SIZE'(1)) begin
              r_state <= ST_DONE;
              r_br    <= 1'b0;
            end else begin
`ifdef DMA_CYCLE_STEAL_EN
              r_state <= ST_RELEASE;
              r_br    <= 1'b0;
`else
              r_state <= ST_REQ;
`endif
            end
          end
        end

        ST_RELEASE: begin
          r_state <= ST_REQ;
          r_br    <= 1'b1;
        end

        ST_DONE: begin
          // Pulse is registered out of DONE, so it is seen the cycle after
          // DONE, two cycles after an accepted zero-length command.
          r_end_irq <= 1'b1;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          r_br    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready         = (r_state == ST_IDLE);
  assign bus.BR                = r_br;
  assign bus.offset            = r_offset;
  assign bus.mem_write_req     = r_mem_write_req;
  assign bus.mem_addr          = r_mem_addr;
  assign bus.mem_wdata         = r_buffer;
  assign bus.dma_end_interrupt = r_end_irq;
  assign bus.dbg_state         = r_state;

endmodule

// File: tb/tb_dma_controller.sv
// ---------------------------------------------------------------------------
// tb_dma_controller
// Environment: CPU command driver, bus arbiter (BG follows BR one cycle late,
// optionally dropped during writes), device returning a per-offset pattern,
// memory with programmable ack latency. Expected writes are queued when a
// command is issued and popped as the memory acknowledges them.
// ---------------------------------------------------------------------------
module tb_dma_controller;

  localparam int W  = 16;
  localparam int B  = 64;
  localparam int EW = W + B + W;   // {addr, data, offset}

  logic clk;
  logic reset_n;

  dma_controller_if bus ();

  dma_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int             n_vectors     = 0;
  int             n_miscompares = 0;
  logic [EW-1:0]  exp_q[$];
  logic [EW-1:0]  exp_e;

  int             ack_delay   = 0;
  bit             bg_drop     = 1'b0;
  logic [W-1:0]   dev_seed    = '0;
  int             irq_cnt     = 0;
  int             br_rises    = 0;
  int             br_gap      = 0;
  int             writes_done = 0;
  int             wait_cnt    = 0;
  logic           br_d        = 1'b0;
  logic           br_prev     = 1'b0;

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [B-1:0] dev_word(input logic [W-1:0] off);
    return {dev_seed, off, ~off, dev_seed ^ off};
  endfunction

  // ---------------- environment: arbiter, device, memory ----------------
  initial begin
    bus.BG            = 1'b0;
    bus.dev_data      = '0;
    bus.mem_write_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.dma_end_interrupt) irq_cnt++;

      // bus request tracking: every re-request must follow exactly one low cycle
      if (bus.BR) begin
        if (!br_prev) begin
          if (br_rises > 0) check("br_gap", EW'(br_gap), EW'(1));
          br_rises++;
          br_gap = 0;
        end
      end else if (br_rises > 0) begin
        br_gap++;
      end
      br_prev = bus.BR;

      bus.BG   = (bg_drop && bus.mem_write_req) ? 1'b0 : br_d;
      br_d     = bus.BR;
      bus.dev_data = dev_word(bus.offset);

      if (bus.mem_write_req) begin
        check("write_expected", EW'(exp_q.size() != 0), EW'(1));
        if (exp_q.size() != 0) begin
          exp_e = exp_q[0];
          check("mem_addr",  EW'(bus.mem_addr),  EW'(exp_e[EW-1 -: W]));
          check("mem_wdata", EW'(bus.mem_wdata), EW'(exp_e[W +: B]));
          check("offset",    EW'(bus.offset),    EW'(exp_e[W-1:0]));
          if (wait_cnt >= ack_delay) begin
            bus.mem_write_ack = 1'b1;
            void'(exp_q.pop_front());
            wait_cnt = 0;
            writes_done++;
          end else begin
            bus.mem_write_ack = 1'b0;
            wait_cnt++;
          end
        end else begin
          bus.mem_write_ack = 1'b1;
        end
      end else begin
        bus.mem_write_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic setup_xfer(input logic [W-1:0] addr, input int nblk, input int delay, input bit drop);
    ack_delay   = delay;
    bg_drop     = drop;
    dev_seed    = W'($urandom_range(0, 65535));
    irq_cnt     = 0;
    br_rises    = 0;
    writes_done = 0;
    exp_q.delete();
    for (int k = 0; k < nblk; k++) begin
      logic [W-1:0] off;
      off = W'(4 * k);
      exp_q.push_back({addr + off, dev_word(off), off});
    end
  endtask

  task automatic run_cmd(input string tag, input logic [W-1:0] addr, input logic [W-1:0] len,
                         input int delay, input bit drop, input bit spurious, input int exp_lat);
    int nblk;
    int lat;
    int exp_rises;
    nblk = (int'(len) + 3) / 4;
`ifdef DMA_CYCLE_STEAL_EN
    exp_rises = nblk;
`else
    exp_rises = (nblk == 0) ? 0 : 1;
`endif
    setup_xfer(addr, nblk, delay, drop);
    bus.cmd_addr   = addr;
    bus.cmd_length = len;
    bus.cmd_valid  = 1'b1;
    lat = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 1) bus.cmd_valid = 1'b0;
      if (spurious && i == 3) begin
        bus.cmd_valid  = 1'b1;
        bus.cmd_addr   = addr ^ 16'h5a5a;
        bus.cmd_length = 16'd40;
      end
      if (spurious && i == 4) bus.cmd_valid = 1'b0;
      if (bus.dma_end_interrupt) begin
        lat = i;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    check({tag, "_irq_seen"}, EW'(lat != 0), EW'(1));
    if (exp_lat > 0) check({tag, "_irq_latency"}, EW'(lat), EW'(exp_lat));
    repeat (4) @(negedge clk);
    check({tag, "_irq_count"},   EW'(irq_cnt),      EW'(1));
    check({tag, "_writes"},      EW'(writes_done),  EW'(nblk));
    check({tag, "_queue_left"},  EW'(exp_q.size()), EW'(0));
    check({tag, "_br_rises"},    EW'(br_rises),     EW'(exp_rises));
    check({tag, "_cmd_ready"},   EW'(bus.cmd_ready), EW'(1));
    check({tag, "_br_idle"},     EW'(bus.BR),       EW'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_br"},      EW'(bus.BR),                EW'(0));
    check({tag, "_req"},     EW'(bus.mem_write_req),     EW'(0));
    check({tag, "_irq"},     EW'(bus.dma_end_interrupt), EW'(0));
    check({tag, "_offset"},  EW'(bus.offset),            EW'(0));
    check({tag, "_addr"},    EW'(bus.mem_addr),          EW'(0));
    check({tag, "_wdata"},   EW'(bus.mem_wdata),         EW'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    reset_n        = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_length = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check("reset_cmd_ready", EW'(bus.cmd_ready), EW'(1));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd("burst12", 16'h0100, 16'd12, 0, 1'b0, 1'b0, 0);
    run_cmd("len0",    16'h1234, 16'd0,  0, 1'b0, 1'b0, 2);
    run_cmd("len5",    16'h0040, 16'd5,  0, 1'b0, 1'b1, 0);
    run_cmd("slow_ack", 16'h2000, 16'd8, 5, 1'b1, 1'b0, 0);
    run_cmd("wrap",    16'hfffc, 16'd8,  $urandom_range(0, 3), 1'b0, 1'b0, 0);
    for (int r = 0; r < 4; r++) begin
      run_cmd("rand", W'($urandom_range(0, 65535)), W'($urandom_range(1, 20)),
              $urandom_range(0, 2), 1'(r & 1), 1'b0, 0);
    end

    // reset in the middle of the second block
    setup_xfer(16'h0300, 3, 4, 1'b0);
    bus.cmd_addr   = 16'h0300;
    bus.cmd_length = 16'd12;
    bus.cmd_valid  = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (writes_done == 1 && bus.mem_write_req) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_reset_reached", EW'(found), EW'(1));
    #2 reset_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    repeat (10) @(negedge clk);
    check("mid_reset_no_irq",    EW'(irq_cnt),       EW'(0));
    check("mid_reset_cmd_ready", EW'(bus.cmd_ready), EW'(1));
    check("mid_reset_br",        EW'(bus.BR),        EW'(0));

    run_cmd("after_reset", 16'h0500, 16'd4, 1, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
